// File: rtl/inst_mem_loader.sv
// Assembles a little-endian byte stream into 32-bit words and writes them into
// the instruction memory. The core is held in reset until the image is loaded.
// Optional trailing checksum byte: define INST_MEM_LOADER_CHECKSUM_EN.
module inst_mem_loader #(
  parameter int REG_SIZE       = 32,
  parameter int MEM_SIZE_IN_KB = 1,
  parameter int NO_OF_WORDS    = MEM_SIZE_IN_KB * 1024 / 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [REG_SIZE-1:0] len_i,
  input  logic                byte_valid_i,
  input  logic [7:0]          byte_i,
  output logic                byte_ready_o,
  output logic                we_o,
  output logic [REG_SIZE-1:0] waddr_o,
  output logic [REG_SIZE-1:0] wdata_o,
  output logic                core_rst_no,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [2:0]          dbg_state_o
);

  // Byte handshake: a byte moves on a rising edge where byte_valid_i and
  // byte_ready_o are both high; byte_ready_o never depends on byte_valid_i.

  localparam logic [REG_SIZE-1:0] MAX_LEN = REG_SIZE'(NO_OF_WORDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    , S_CSUM = 3'd4
`endif
  } state_t;

  state_t              state_q, state_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [REG_SIZE-1:0] len_q;
  logic [REG_SIZE-1:0] word_idx_q;
  logic [1:0]          byte_cnt_q;
  logic [23:0]         asm_q;
  logic [REG_SIZE-1:0] waddr_q;
  logic [REG_SIZE-1:0] wdata_q;
  logic                start_take;
  logic                rx_fire;
  logic                last_word;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q;
`endif

  assign start_take = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i;
  assign rx_fire    = (state_q == S_RECV) && byte_valid_i;
  assign last_word  = (word_idx_q + REG_SIZE'(1)) == len_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    done_d       = done_q;
    err_d        = err_q;
    byte_ready_o = 1'b0;
    busy_o       = 1'b0;
    we_o         = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          done_d = 1'b0;
          err_d  = 1'b0;
          if (len_i == '0) begin
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
            done_d  = 1'b1;
`endif
          end else if (len_i > MAX_LEN) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = S_RECV;
          end
        end
      end
      S_RECV: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (byte_valid_i && (byte_cnt_q == 2'd3)) state_d = S_WRITE;
      end
      S_WRITE: begin
        busy_o = 1'b1;
        we_o   = 1'b1;
        if (last_word) begin
`ifdef INST_MEM_LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = S_RECV;
        end
      end
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (byte_valid_i) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = (byte_i != csum_q);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: counters, word assembly and the held write address/data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q      <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= 2'd0;
      asm_q      <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      if (start_take) begin
        len_q      <= len_i;
        word_idx_q <= '0;
        byte_cnt_q <= 2'd0;
        asm_q      <= '0;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
        csum_q     <= '0;
`endif
      end
      if (rx_fire) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
        csum_q     <= csum_q + byte_i;
`endif
        case (byte_cnt_q)
          2'd0: asm_q[7:0]   <= byte_i;
          2'd1: asm_q[15:8]  <= byte_i;
          2'd2: asm_q[23:16] <= byte_i;
          default: begin
            // Fourth byte completes the word; address and data are captured
            // here so they stay stable through WRITE and afterwards.
            wdata_q <= REG_SIZE'({byte_i, asm_q});
            waddr_q <= {word_idx_q[REG_SIZE-3:0], 2'b00};
          end
        endcase
      end
      if (state_q == S_WRITE) begin
        word_idx_q <= word_idx_q + REG_SIZE'(1);
        byte_cnt_q <= 2'd0;
      end
    end
  end

  assign waddr_o     = waddr_q;
  assign wdata_o     = wdata_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign core_rst_no = (state_q == S_DONE) && !err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized scoreboard bench for inst_mem_loader; expected writes come from a
// byte-list model and are popped by a monitor whenever we_o is seen.
module tb_inst_mem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] len;
  logic        byte_valid;
  logic [7:0]  byte_d;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  logic [7:0]  pay_q[$];

  inst_mem_loader dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .len_i       (len),
    .byte_valid_i(byte_valid),
    .byte_i      (byte_d),
    .byte_ready_o(byte_ready),
    .we_o        (we),
    .waddr_o     (waddr),
    .wdata_o     (wdata),
    .core_rst_no (core_rst_n),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: every write must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", {31'd0, we}, 32'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("waddr", waddr, e[63:32]);
        check("wdata", wdata, e[31:0]);
      end
    end
  end

  // driver tasks (all input changes happen 1 time unit after a rising edge)
  task automatic pulse_start(input logic [31:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
    len   = $urandom;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    int t;
    repeat (stall) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_d     = b;
    t = 0;
    while (!byte_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!byte_ready) check("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_d     = $urandom;
  endtask

  task automatic fill_random(input int nbytes);
    pay_q.delete();
    for (int i = 0; i < nbytes; i++) pay_q.push_back(8'($urandom));
  endtask

  // Full load of pay_q as nwords words; the model pushes one (addr,data) pair per word.
  task automatic run_load(input int nwords, input int smin, input int smax,
                          input bit csum_bad, input int glitch_at);
    logic [7:0] sum;
    bit exp_err;
    sum = 8'd0;
    exp_err = 1'b0;
    for (int w = 0; w < nwords; w++)
      exp_q.push_back({32'(w * 4), pay_q[4*w+3], pay_q[4*w+2], pay_q[4*w+1], pay_q[4*w]});
    pulse_start(32'(nwords));
    for (int i = 0; i < 4 * nwords; i++) begin
      if (i == glitch_at) pulse_start(32'd3);
      sum = sum + pay_q[i];
      send_byte(pay_q[i], $urandom_range(smax, smin));
    end
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    exp_err = csum_bad;
    send_byte(csum_bad ? sum + 8'd1 : sum, $urandom_range(smax, smin));
`else
    @(posedge clk); #1;
`endif
    check("load_done", {31'd0, done}, 32'd1);
    check("load_err", {31'd0, err}, {31'd0, exp_err});
    check("load_core_rst_n", {31'd0, core_rst_n}, {31'd0, !exp_err});
    check("load_busy", {31'd0, busy}, 32'd0);
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"}, {31'd0, we}, 32'd0);
    check({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_core_rst_n"}, {31'd0, core_rst_n}, 32'd0);
    check({tag, "_waddr"}, waddr, 32'd0);
    check({tag, "_wdata"}, wdata, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    len = 32'd0;
    byte_valid = 1'b0;
    byte_d = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic two-word load with fixed bytes
    pay_q = '{8'h13, 8'h05, 8'h00, 8'h00, 8'hB3, 8'h02, 8'h55, 8'h00};
    run_load(2, 0, 0, 1'b0, -1);

    // bytes offered while DONE must not be consumed
    byte_valid = 1'b1;
    byte_d = 8'hAA;
    repeat (4) begin
      @(posedge clk); #1;
      check("done_byte_ready", {31'd0, byte_ready}, 32'd0);
    end
    byte_valid = 1'b0;
    check("done_held", {31'd0, done}, 32'd1);

    // stalled input
    pay_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(1, 3, 3, 1'b0, -1);

    // oversize length: error, no writes
    pulse_start(32'd257);
    check("oversize_done", {31'd0, done}, 32'd1);
    check("oversize_err", {31'd0, err}, 32'd1);
    check("oversize_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    check("oversize_busy", {31'd0, busy}, 32'd0);

    // zero length
    pay_q.delete();
    run_load(0, 0, 0, 1'b0, -1);

    // reset in the middle of a two-word load: only word 0 reaches memory
    fill_random(8);
    exp_q.push_back({32'd0, pay_q[3], pay_q[2], pay_q[1], pay_q[0]});
    pulse_start(32'd2);
    for (int i = 0; i < 6; i++) send_byte(pay_q[i], 0);
    rst_n = 1'b0;
    #1;
    check("midreset_writes_outstanding", 32'(exp_q.size()), 32'd0);
    check_idle_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill_random(4);
    run_load(1, 0, 1, 1'b0, -1);

    // start pulsed during RECV is ignored
    fill_random(8);
    run_load(2, 0, 1, 1'b0, 2);

    // full memory
    fill_random(1024);
    run_load(256, 0, 0, 1'b0, -1);

    // random loads
    for (int r = 0; r < 8; r++) begin
      int nw;
      nw = $urandom_range(6, 1);
      fill_random(4 * nw);
      run_load(nw, 0, 2, 1'($urandom_range(1, 0)), -1);
    end

`ifdef INST_MEM_LOADER_CHECKSUM_EN
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(1, 0, 0, 1'b0, -1);
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(1, 0, 0, 1'b1, -1);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("final_writes_outstanding", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writer-side counterpart of the core's read-only instruction memory.
- Accepts a byte stream (e.g. from a UART receiver) and assembles little-endian 32-bit instruction words.
- Issues one write per word into the instruction memory's write port at byte-addressed, word-aligned addresses.
- Holds the core in reset until the program image is completely loaded.

Parameters:
- REG_SIZE, 32, width of data and address words.
- MEM_SIZE_IN_KB, 1, instruction memory size in KB.
- NO_OF_WORDS, MEM_SIZE_IN_KB*1024/4, capacity in 32-bit words.

Ports:
- clk_i  in  1  single clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- start_i  in  1  one-cycle pulse that starts a load; sampled only in IDLE or DONE.
- len_i  in  REG_SIZE  number of words to load; sampled with start_i.
- byte_valid_i  in  1  input byte valid.
- byte_i  in  8  input byte.
- byte_ready_o  out  1  loader can accept a byte; a transfer happens when valid and ready are both high.
- we_o  out  1  instruction memory write enable, one-cycle pulse.
- waddr_o  out  REG_SIZE  byte address = word_index<<2; bits [1:0] are always 0.
- wdata_o  out  REG_SIZE  assembled instruction word.
- core_rst_no  out  1  active-low reset to the core; 0 while not loaded.
- busy_o  out  1  load in progress.
- done_o  out  1  load finished; held until the next start_i.
- err_o  out  1  load aborted or failed; held until the next start_i.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, byte counter 0, word index 0, assembly register 0. core_rst_no=0, so the core is held in reset.
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE: byte_ready_o=0. On start_i:
  - len_i==0 -> DONE with done_o=1.
  - len_i>NO_OF_WORDS -> DONE with err_o=1 and done_o=1; no writes, core_rst_no stays 0.
  - Otherwise latch len, clear counters, core_rst_no=0 -> RECV.
- RECV: byte_ready_o=1, busy_o=1.
  - Each handshake places the byte at bits [8*k+7:8*k], where k is the byte counter 0..3, then increments k.
  - On the 4th byte (k==3), the next state is WRITE.
  - Cycles with byte_valid_i=0 are stall cycles with no state change.
- WRITE (exactly 1 cycle): byte_ready_o=0, we_o=1, waddr_o=word_index*4, wdata_o=assembled word.
  - Then word_index increments and k resets to 0.
  - If word_index+1==len -> DONE with done_o=1, core_rst_no=1. Otherwise -> RECV.
- Latency: first-byte handshake to we_o pulse is 4 cycles minimum (bytes on consecutive cycles, then WRITE). Peak throughput is one word per 5 cycles.
- DONE: byte_ready_o=0 and busy_o=0; done_o and err_o are held.
  - core_rst_no=1 only if err_o=0.
  - A new start_i clears done_o and err_o the next cycle and re-enters the IDLE decision.
- start_i in RECV or WRITE is ignored.
- Bytes presented while byte_ready_o=0 are not consumed.
- Reset asserted mid-load: the partial word is discarded, no further writes occur, core_rst_no drops to 0 immediately.
- waddr_o and wdata_o hold their last values outside WRITE; only we_o qualifies them.
- Word index width is REG_SIZE. Addresses never exceed (NO_OF_WORDS-1)*4.

Optional Feature:
INST_MEM_LOADER_CHECKSUM_EN
- Defined:
  - After the last WRITE, the FSM enters a CSUM state (byte_ready_o=1) and accepts one trailing byte.
  - The expected value is the 8-bit modulo-256 sum of all payload bytes, including only bytes actually accepted.
  - Match -> DONE with core_rst_no=1. Mismatch -> DONE with err_o=1 and core_rst_no=0; the already-written words remain in memory.
  - len_i==0 with the feature defined: expects checksum byte 0x00.
- Not defined: no CSUM state; behaviour exactly as above.

Test Plan:
- Basic load: len_i=2, bytes 13,05,00,00,B3,02,55,00 back-to-back -> we_o pulses with (0x0,0x00000513) and (0x4,0x005502B3); done_o=1; core_rst_no=1 one cycle after the second write.
- Stalled input: len_i=1, bytes EF,BE,AD,DE with 3 idle cycles between each byte -> single write (0x0,0xDEADBEEF); no write before the 4th byte.
- Error and zero length:
  - len_i=257 (NO_OF_WORDS=256) -> err_o=1, done_o=1, no we_o, core_rst_no=0.
  - len_i=0 -> done_o=1, no we_o.
- Reset mid-load: reset after 6 bytes of a 2-word load -> exactly one write (address 0x0); after reset all outputs are 0. A restart with len_i=1 writes at address 0x0.
- Ignored start and full memory: start_i pulsed during RECV -> no effect. A len_i=256 load ends with a last write at address 0x3FC.
- Checksum (macro defined): len_i=1, bytes 01,02,03,04, then checksum 0x0A -> core_rst_no=1. The same load with checksum 0x0B -> err_o=1, core_rst_no=0.
